// File: rtl/mem_bus_master_pkg.sv
// Shared definitions for the memory bus master: request op codes, FSM
// state encodings, bit-addressable RAM base and small datapath helpers.
package mem_bus_master_pkg;

    typedef enum logic [1:0] {
        BUS_RD_BYTE = 2'b00,
        BUS_WR_BYTE = 2'b01,
        BUS_RD_BIT  = 2'b10,
        BUS_WR_BIT  = 2'b11
    } bus_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_MOD  = 3'd2,
        ST_WR   = 3'd3,
        ST_RSP  = 3'd4
    } bus_state_e;

    // Bit addresses below 0x80 map onto RAM bytes 0x20..0x2F.
    localparam logic [7:0] BIT_RAM_BASE = 8'h20;

    // Replace one bit of a byte (read-modify-write merge).
    function automatic logic [7:0] merge_bit(input logic [7:0] byte_in,
                                             input logic [2:0] idx,
                                             input logic       bit_val);
        logic [7:0] res;
        res      = byte_in;
        res[idx] = bit_val;
        return res;
    endfunction

    // Code space is read-only and not bit-addressable: only byte reads are legal there.
    function automatic logic is_illegal(input logic [1:0] op, input logic space);
        return (space == 1'b0) && (op != BUS_RD_BYTE);
    endfunction

endpackage

// File: rtl/mem_bus_master_bit_addr_decode.sv
// bit_addr_decode: combinational bit address -> {byte address, bit index}.
//   bit_addr  in  8  bit address
//   byte_addr out 8  containing byte (0x20..0x2F for RAM bits, 8-aligned SFR otherwise)
//   bit_idx   out 3  bit position inside that byte
module bit_addr_decode
    import mem_bus_master_pkg::*;
(
    input  logic [7:0] bit_addr,
    output logic [7:0] byte_addr,
    output logic [2:0] bit_idx
);

    // Low half addresses RAM bits, high half addresses bits of 8-aligned SFRs.
    always_comb begin
        byte_addr = 8'h00;
        if (bit_addr[7] == 1'b0) begin
            byte_addr = BIT_RAM_BASE + {4'h0, bit_addr[6:3]};
        end else begin
            byte_addr = {bit_addr[7:3], 3'b000};
        end
    end

    assign bit_idx = bit_addr[2:0];

endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: CPU-side initiator for the MCU memory bus. Turns single core
// requests into byte reads/writes and bit reads/writes (bit writes as
// read-modify-write). All outputs are registered from the next-state values.
//   clk, reset                       clock, synchronous active-high reset
//   req_valid/req_ready/req_op/req_space/req_addr/req_wdata  core request
//   rsp_valid/rsp_rdata/rsp_err      completion pulse and held result
//   addr_bus/read_en/write_en/memory_select/data_out/data_in  memory bus
module mem_bus_master
    import mem_bus_master_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic        req_space,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] addr_bus,
    output logic        read_en,
    output logic        write_en,
    output logic        memory_select,
    output logic [7:0]  data_out,
    input  logic [7:0]  data_in
);

    localparam int             CNT_W    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    bus_state_e       state_r, state_s;
    bus_op_e          op_r, op_s;
    logic             space_r, space_s;
    logic [15:0]      bus_addr_r, bus_addr_s;
    logic [7:0]       wbyte_r, wbyte_s;
    logic             wbit_r, wbit_s;
    logic [2:0]       idx_r, idx_s;
    logic [7:0]       rbyte_r, rbyte_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [7:0]       rsp_rdata_s;
    logic             rsp_err_s;
    logic [7:0]       dec_byte_s;
    logic [2:0]       dec_idx_s;

    logic             req_ready_s, rsp_valid_s, read_en_s, write_en_s, memory_select_s;
    logic [15:0]      addr_bus_s;
    logic [7:0]       data_out_s;

    bit_addr_decode u_bit_addr_decode (
        .bit_addr  (req_addr[7:0]),
        .byte_addr (dec_byte_s),
        .bit_idx   (dec_idx_s)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            op_r       <= BUS_RD_BYTE;
            space_r    <= 1'b0;
            bus_addr_r <= 16'h0000;
            wbyte_r    <= 8'h00;
            wbit_r     <= 1'b0;
            idx_r      <= 3'd0;
            rbyte_r    <= 8'h00;
            cnt_r      <= '0;
        end else begin
            state_r    <= state_s;
            op_r       <= op_s;
            space_r    <= space_s;
            bus_addr_r <= bus_addr_s;
            wbyte_r    <= wbyte_s;
            wbit_r     <= wbit_s;
            idx_r      <= idx_s;
            rbyte_r    <= rbyte_s;
            cnt_r      <= cnt_s;
        end
    end

    // Next-state, request capture, wait counting and response result.
    always_comb begin
        state_s     = state_r;
        op_s        = op_r;
        space_s     = space_r;
        bus_addr_s  = bus_addr_r;
        wbyte_s     = wbyte_r;
        wbit_s      = wbit_r;
        idx_s       = idx_r;
        rbyte_s     = rbyte_r;
        cnt_s       = cnt_r;
        rsp_rdata_s = rsp_rdata;
        rsp_err_s   = rsp_err;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    op_s    = bus_op_e'(req_op);
                    space_s = req_space;
                    wbyte_s = req_wdata;
                    wbit_s  = req_wdata[0];
                    idx_s   = dec_idx_s;
                    cnt_s   = '0;
                    // Bit ops and internal space both live in the 256-byte internal map.
                    if (req_op[1]) begin
                        bus_addr_s = {8'h00, dec_byte_s};
                    end else if (req_space) begin
                        bus_addr_s = {8'h00, req_addr[7:0]};
                    end else begin
                        bus_addr_s = req_addr;
                    end
                    if (is_illegal(req_op, req_space)) begin
                        state_s     = ST_RSP;
                        rsp_err_s   = 1'b1;
                        rsp_rdata_s = 8'h00;
                    end else if (req_op == BUS_WR_BYTE) begin
                        state_s = ST_WR;
                    end else begin
                        state_s = ST_RD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (cnt_r == CNT_LAST) begin
                    rbyte_s = data_in;
                    cnt_s   = '0;
                    if (op_r == BUS_WR_BIT) begin
                        state_s = ST_MOD;
                    end else begin
                        state_s     = ST_RSP;
                        rsp_err_s   = 1'b0;
                        rsp_rdata_s = (op_r == BUS_RD_BIT) ? {7'b0000000, data_in[idx_r]} : data_in;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_MOD: begin
                wbyte_s = merge_bit(rbyte_r, idx_r, wbit_r);
                cnt_s   = '0;
                state_s = ST_WR;
            end
            ST_WR: begin
                if (cnt_r == CNT_LAST) begin
                    state_s     = ST_RSP;
                    rsp_err_s   = 1'b0;
                    rsp_rdata_s = 8'h00;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_RSP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state so they can be registered.
    always_comb begin
        req_ready_s     = (state_s == ST_IDLE);
        rsp_valid_s     = (state_s == ST_RSP);
        read_en_s       = (state_s == ST_RD);
        write_en_s      = (state_s == ST_WR);
        addr_bus_s      = 16'h0000;
        memory_select_s = 1'b0;
        data_out_s      = 8'h00;
        if (read_en_s || write_en_s) begin
            addr_bus_s      = bus_addr_s;
            memory_select_s = space_s;
        end else begin
            addr_bus_s      = 16'h0000;
            memory_select_s = 1'b0;
        end
        if (write_en_s) begin
            data_out_s = wbyte_s;
        end else begin
            data_out_s = 8'h00;
        end
    end

    // Output registers; reset aborts any transfer on the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= 8'h00;
            rsp_err       <= 1'b0;
            addr_bus      <= 16'h0000;
            read_en       <= 1'b0;
            write_en      <= 1'b0;
            memory_select <= 1'b0;
            data_out      <= 8'h00;
        end else begin
            req_ready     <= req_ready_s;
            rsp_valid     <= rsp_valid_s;
            rsp_rdata     <= rsp_rdata_s;
            rsp_err       <= rsp_err_s;
            addr_bus      <= addr_bus_s;
            read_en       <= read_en_s;
            write_en      <= write_en_s;
            memory_select <= memory_select_s;
            data_out      <= data_out_s;
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: one instance with WAIT_STATES=0
// (index 0) and one with WAIT_STATES=2 (index 1) share the request inputs;
// each vector resets both and checks the selected instance cycle by cycle.
module tb_mem_bus_master;
    import mem_bus_master_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [1:0]  req_op;
    logic        req_space;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic [7:0]  data_in;

    logic        req_ready_a[2];
    logic        rsp_valid_a[2];
    logic [7:0]  rsp_rdata_a[2];
    logic        rsp_err_a[2];
    logic [15:0] addr_bus_a[2];
    logic        read_en_a[2];
    logic        write_en_a[2];
    logic        memory_select_a[2];
    logic [7:0]  data_out_a[2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_bus_master #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_a[0]),
        .req_op(req_op), .req_space(req_space), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a[0]), .rsp_rdata(rsp_rdata_a[0]), .rsp_err(rsp_err_a[0]),
        .addr_bus(addr_bus_a[0]), .read_en(read_en_a[0]), .write_en(write_en_a[0]),
        .memory_select(memory_select_a[0]), .data_out(data_out_a[0]), .data_in(data_in)
    );

    mem_bus_master #(.WAIT_STATES(2)) dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_a[1]),
        .req_op(req_op), .req_space(req_space), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a[1]), .rsp_rdata(rsp_rdata_a[1]), .rsp_err(rsp_err_a[1]),
        .addr_bus(addr_bus_a[1]), .read_en(read_en_a[1]), .write_en(write_en_a[1]),
        .memory_select(memory_select_a[1]), .data_out(data_out_a[1]), .data_in(data_in)
    );

    typedef struct {
        int          sel;
        logic [1:0]  op;
        logic        space;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  din;
        int          rd_n;
        int          wr_n;
        int          rd_last;
        logic [15:0] ex_addr;
        logic        ex_msel;
        logic [7:0]  ex_dout;
        int          rsp_cyc;
        logic        ex_err;
        logic        chk_rdata;
        logic [7:0]  ex_rdata;
        string       name;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int s;
        int rd_c, wr_c, bad_a, bad_d, ovl, rsp_at;
        s = v.sel;
        rd_c = 0; wr_c = 0; bad_a = 0; bad_d = 0; ovl = 0; rsp_at = 0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check({v.name, ".ready_idle"}, 32'(req_ready_a[s]), 32'd1);
        req_valid = 1'b1; req_op = v.op; req_space = v.space;
        req_addr = v.addr; req_wdata = v.wdata; data_in = 8'hEE;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            // Scramble request fields while busy; the captured request must stand.
            req_op = ~v.op; req_space = ~v.space; req_addr = ~v.addr; req_wdata = ~v.wdata;
            data_in = (k == v.rd_last) ? v.din : 8'hEE;
            if (read_en_a[s]) rd_c++;
            if (write_en_a[s]) wr_c++;
            if (read_en_a[s] && write_en_a[s]) ovl++;
            if (read_en_a[s] || write_en_a[s]) begin
                if (addr_bus_a[s] !== v.ex_addr || memory_select_a[s] !== v.ex_msel) bad_a++;
            end else begin
                if (addr_bus_a[s] !== 16'h0000 || memory_select_a[s] !== 1'b0) bad_a++;
            end
            if (write_en_a[s]) begin
                if (data_out_a[s] !== v.ex_dout) bad_d++;
            end else begin
                if (data_out_a[s] !== 8'h00) bad_d++;
            end
            if (rsp_valid_a[s]) begin
                rsp_at = k;
                req_valid = 1'b0;
                check({v.name, ".rsp_err"}, 32'(rsp_err_a[s]), 32'(v.ex_err));
                if (v.chk_rdata) check({v.name, ".rsp_rdata"}, 32'(rsp_rdata_a[s]), 32'(v.ex_rdata));
                break;
            end
        end
        req_valid = 1'b0;
        check({v.name, ".rd_cycles"}, 32'(rd_c), 32'(v.rd_n));
        check({v.name, ".wr_cycles"}, 32'(wr_c), 32'(v.wr_n));
        check({v.name, ".rsp_cycle"}, 32'(rsp_at), 32'(v.rsp_cyc));
        check({v.name, ".addr_msel"}, 32'(bad_a), 32'd0);
        check({v.name, ".data_out"}, 32'(bad_d), 32'd0);
        check({v.name, ".rd_wr_overlap"}, 32'(ovl), 32'd0);
        @(negedge clk);
        check({v.name, ".ready_after"}, 32'(req_ready_a[s]), 32'd1);
        check({v.name, ".rsp_one_cycle"}, 32'(rsp_valid_a[s]), 32'd0);
        check({v.name, ".err_held"}, 32'(rsp_err_a[s]), 32'(v.ex_err));
        if (v.chk_rdata) check({v.name, ".rdata_held"}, 32'(rsp_rdata_a[s]), 32'(v.ex_rdata));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        //            sel op    sp addr      wd     din    rd wr last ex_addr   ms dout   rsp err chk rdata  name
        vecs[0]  = '{0, 2'b00, 1, 16'h0045, 8'h00, 8'h5A, 1, 0, 1, 16'h0045, 1, 8'h00, 2, 0, 1, 8'h5A, "rd_byte_int_w0"};
        vecs[1]  = '{1, 2'b00, 0, 16'h1234, 8'h00, 8'h77, 3, 0, 3, 16'h1234, 0, 8'h00, 4, 0, 1, 8'h77, "rd_byte_code_w2"};
        vecs[2]  = '{0, 2'b01, 0, 16'h0100, 8'h3C, 8'h00, 0, 0, 0, 16'h0000, 0, 8'h00, 1, 1, 0, 8'h00, "wr_byte_code_err"};
        vecs[3]  = '{0, 2'b11, 1, 16'h000B, 8'h01, 8'h00, 1, 1, 1, 16'h0021, 1, 8'h08, 4, 0, 0, 8'h00, "wr_bit_0b"};
        vecs[4]  = '{0, 2'b11, 1, 16'h008E, 8'h00, 8'hFF, 1, 1, 1, 16'h0088, 1, 8'hBF, 4, 0, 0, 8'h00, "wr_bit_8e"};
        vecs[5]  = '{0, 2'b10, 1, 16'h008E, 8'h00, 8'hBF, 1, 0, 1, 16'h0088, 1, 8'h00, 2, 0, 1, 8'h00, "rd_bit_8e"};
        vecs[6]  = '{0, 2'b10, 1, 16'h0AB3, 8'h00, 8'h08, 1, 0, 1, 16'h00B0, 1, 8'h00, 2, 0, 1, 8'h01, "rd_bit_b3"};
        vecs[7]  = '{1, 2'b01, 1, 16'h12C4, 8'hA5, 8'h00, 0, 3, 0, 16'h00C4, 1, 8'hA5, 4, 0, 0, 8'h00, "wr_byte_int_w2"};
        vecs[8]  = '{1, 2'b11, 1, 16'h007F, 8'h01, 8'h00, 3, 3, 3, 16'h002F, 1, 8'h80, 8, 0, 0, 8'h00, "wr_bit_7f_w2"};
        vecs[9]  = '{0, 2'b10, 0, 16'h0010, 8'h00, 8'h00, 0, 0, 0, 16'h0000, 0, 8'h00, 1, 1, 0, 8'h00, "rd_bit_code_err"};
        vecs[10] = '{0, 2'b00, 0, 16'hFFFF, 8'h00, 8'hC3, 1, 0, 1, 16'hFFFF, 0, 8'h00, 2, 0, 1, 8'hC3, "rd_byte_code_ffff"};
        vecs[11] = '{1, 2'b11, 0, 16'h0033, 8'h01, 8'h00, 0, 0, 0, 16'h0000, 0, 8'h00, 1, 1, 0, 8'h00, "wr_bit_code_err_w2"};

        reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_space = 1'b0;
        req_addr = 16'h0000; req_wdata = 8'h00; data_in = 8'h00;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset%0d.req_ready", i), 32'(req_ready_a[i]), 32'd1);
            check($sformatf("reset%0d.outputs", i),
                  {7'd0, rsp_valid_a[i], rsp_rdata_a[i], addr_bus_a[i]}, 32'd0);
            check($sformatf("reset%0d.strobes", i),
                  32'({rsp_err_a[i], read_en_a[i], write_en_a[i], memory_select_a[i], data_out_a[i]}), 32'd0);
        end
        reset = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Abort a bit write with reset while it sits in MOD.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        req_valid = 1'b1; req_op = 2'b11; req_space = 1'b1; req_addr = 16'h000B; req_wdata = 8'h01;
        data_in = 8'h00;
        @(negedge clk); req_valid = 1'b0;
        check("abort.in_rd", 32'(read_en_a[0]), 32'd1);
        @(negedge clk);
        check("abort.in_mod", 32'({read_en_a[0], write_en_a[0]}), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("abort.outputs_zero",
              {rsp_rdata_a[0], addr_bus_a[0], data_out_a[0]}, 32'd0);
        check("abort.strobes_zero",
              32'({rsp_valid_a[0], rsp_err_a[0], read_en_a[0], write_en_a[0], memory_select_a[0],
                   read_en_a[1], write_en_a[1]}), 32'd0);
        check("abort.ready", 32'(req_ready_a[0]), 32'd1);
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (write_en_a[0] || rsp_valid_a[0] || !req_ready_a[0]) bad++;
        end
        check("abort.no_write_no_rsp", 32'(bad), 32'd0);

        // Recovery after the abort.
        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
